// File: rtl/mux_arb_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
//   N_REQ   : number of requesters sharing the output channel
//   SEL_W   : width of the requester index / mux select
//   state_e : output holding-register state (IDLE = empty, BUSY = word held)
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker for four requesters.
//   req    in  : request vector, bit i from requester i
//   ptr    in  : highest-priority index for this cycle
//   any    out : at least one request is present
//   winner out : first requesting index searching ptr, ptr+1, ... (mod 4)
//   onehot out : one-hot form of winner, zero when no request
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] winner,
  output logic [N_REQ-1:0] onehot
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [SEL_W:0]     rot_idx;
  logic [SEL_W-1:0]   offset;

  // Rotate so that the requester at ptr lands in bit 0, priority-encode the
  // lowest set bit, then add ptr back to recover the absolute index.
  always_comb begin
    req_dbl = {req, req};
    rot_idx = {1'b0, ptr};
    req_rot = req_dbl[rot_idx +: N_REQ];
    offset  = '0;
    for (int unsigned j = N_REQ; j > 0; j--) begin
      if (req_rot[j-1]) offset = SEL_W'(j - 1);
    end
    any    = |req;
    winner = ptr + offset;
    onehot = any ? (N_REQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one registered output channel between four
// requesters, and driving the select of the downstream 4:1 data mux.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req[3:0]         : requester i holds a valid word on data_i
//   data_0..data_3   : requester words
//   ack[3:0]         : combinational one-hot capture strobe
//   sel              : index of the last captured requester
//   out_valid        : out_data holds an untransferred word
//   out_data         : registered word of requester sel
//   out_ready        : consumer accepts out_data when out_valid & out_ready
//   busy             : same as out_valid
module rr_mux4_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  output logic [N_REQ-1:0]  ack,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              any;
  logic [SEL_W-1:0]  winner;
  logic [N_REQ-1:0]  onehot;
  logic              cap;
  logic [DATA_W-1:0] win_data;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .winner (winner),
    .onehot (onehot)
  );

  always_comb begin
    win_data = data_0;
    unique case (winner)
      2'd0: win_data = data_0;
      2'd1: win_data = data_1;
      2'd2: win_data = data_2;
      2'd3: win_data = data_3;
      default: win_data = data_0;
    endcase
  end

  // Capture when the holding register is empty or drains this cycle.
  // rst_n gates cap so that ack stays low while reset is asserted.
  always_comb begin
    cap        = rst_n & any & ((state_q == IDLE) | out_ready);
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    out_data_d = out_data_q;
    if (cap) begin
      state_d    = BUSY;
      ptr_d      = winner + SEL_W'(1);
      sel_d      = winner;
      out_data_d = win_data;
    end else if ((state_q == BUSY) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      out_data_q <= out_data_d;
    end
  end

  assign ack       = cap ? onehot : '0;
  assign sel       = sel_q;
  assign out_valid = (state_q == BUSY);
  assign busy      = out_valid;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural channel model.
module tb_rr_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] d [4];
  logic [3:0] ack;
  logic [1:0] sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: priority pointer plus a one-entry holding register.
  int         m_ptr;
  bit         m_valid;
  int         m_sel;
  logic [7:0] m_data;
  logic [3:0] last_ack;

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_0    (d[0]),
    .data_1    (d[1]),
    .data_2    (d[2]),
    .data_3    (d[3]),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_sel   = 0;
    m_data  = 8'h00;
  endtask

  // One cycle: drive at the falling edge, check shortly after, clock, update model.
  task automatic step(input logic [3:0] r, input logic rdy);
    int         w;
    logic [3:0] exp_ack;
    req       = r;
    out_ready = rdy;
    #1;
    w       = model_winner(r);
    exp_ack = 4'b0000;
    if (w >= 0 && (!m_valid || rdy)) exp_ack = 4'b0001 << w;
    check("ack", ack, exp_ack);
    check("out_valid", out_valid, m_valid);
    check("busy", busy, m_valid);
    check("sel", sel, m_sel);
    check("out_data", out_data, m_data);
    last_ack = ack;
    @(posedge clk);
    if (exp_ack != 4'b0000) begin
      m_data  = d[w];
      m_sel   = w;
      m_ptr   = (w + 1) % 4;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    model_reset();

    // Reset with all requests high.
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sel", sel, 2'd0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_ack", ack, 4'b0000);
    @(negedge clk);
    check("rst_ack_hold", ack, 4'b0000);
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    check("rst_first_ack", last_ack, 4'b0001);
    step(4'b0000, 1'b1);

    // Single request.
    d[2] = 8'hA5;
    step(4'b0100, 1'b1);
    check("single_ack", last_ack, 4'b0100);
    check("single_valid", out_valid, 1'b1);
    check("single_sel", sel, 2'd2);
    check("single_data", out_data, 8'hA5);
    step(4'b0000, 1'b1);
    check("single_drain", out_valid, 1'b0);

    // Round robin with all requests held.
    pulse_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1);
      check("rr_ack", last_ack, 4'b0001 << (k % 4));
      check("rr_valid", out_valid, 1'b1);
      check("rr_data", out_data, 8'h10 + 8'(k % 4));
    end

    // Backpressure: holding word 0x10, pointer at 1.
    for (int k = 0; k < 5; k++) begin
      step(4'b0011, 1'b0);
      check("bp_ack", last_ack, 4'b0000);
      check("bp_data", out_data, 8'h10);
      check("bp_sel", sel, 2'd0);
    end
    step(4'b0011, 1'b1);
    check("bp_release_ack", last_ack, 4'b0010);
    check("bp_release_data", out_data, 8'h11);

    // Wrap and skip.
    step(4'b0100, 1'b1);
    check("wrap_pre_ack", last_ack, 4'b0100);
    step(4'b0001, 1'b1);
    check("wrap_ack", last_ack, 4'b0001);
    step(4'b1001, 1'b1);
    check("skip_ack", last_ack, 4'b1000);
    check("skip_sel", sel, 2'd3);

    // Async reset while holding under backpressure.
    step(4'b0000, 1'b0);
    check("ar_busy", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_valid_async", out_valid, 1'b0);
    check("ar_data_async", out_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    check("ar_ptr0_ack", last_ack, 4'b0001);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      step(4'($urandom), ($urandom_range(3, 0) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
